// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch FSM states, NOP encoding and opcodes shared with decode.
package riscv_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FLUSH} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry output buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);
  fetch_state_t r_state, w_next;
  logic [31:0] r_pc, r_pc_fly, r_inst, r_inst_pc;
  logic r_inst_valid;
  logic w_take, w_fill, w_ack;
  assign w_take = (r_state == REQ) && imem_gnt;
  assign w_fill = (r_state == WAIT) && imem_rvalid;
  assign w_ack  = (r_state == HOLD) && r_inst_valid && inst_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      REQ:     w_next = imem_gnt ? (redirect ? FLUSH : WAIT) : REQ;
      WAIT:    w_next = imem_rvalid ? (redirect ? REQ : HOLD) : (redirect ? FLUSH : WAIT);
      HOLD:    w_next = (redirect || w_ack) ? REQ : HOLD;
      FLUSH:   w_next = imem_rvalid ? REQ : FLUSH;
      default: w_next = REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      r_pc_fly     <= '0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= redirect ? {redirect_pc[31:2], 2'b00} : (w_take ? r_pc + 32'd4 : r_pc);
      if (w_take) r_pc_fly <= r_pc;
      if (w_fill && !redirect) begin
        r_inst    <= imem_rdata;
        r_inst_pc <= r_pc_fly;
      end
      r_inst_valid <= redirect ? 1'b0 : (w_fill ? 1'b1 : (w_ack ? 1'b0 : r_inst_valid));
    end
  end
  assign imem_req   = rst_n && (r_state == REQ);
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign opcode     = r_inst[6:0];
  assign funct3     = r_inst[14:12];
  assign funct7     = r_inst[31:25];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, redirects, wrap and async reset.
module tb_fetch_unit;
  logic clk = 0, rst_n = 0;
  logic imem_gnt = 0, imem_rvalid = 0, redirect = 0, inst_ready = 0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_inst, w_inst_pc;
  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .funct3(funct3), .funct7(funct7));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(w_valid),
    .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc), .opcode(w_opcode),
    .funct3(w_funct3), .funct7(w_funct7));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_gnt = 0; imem_rvalid = 0; redirect = 0; inst_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", inst_valid); end
    checks++; if (inst !== 32'h13) begin errors++; $display("FAIL rst_inst got %h want 00000013", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr got %h want 100", imem_addr); end
    rst_n = 1;
    step();
  endtask

  task automatic test_reset_fetch();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rf_req got %0b/%h want 1/100", imem_req, imem_addr); end
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_wait_req got %0b want 0", imem_req); end
    step();
    imem_rvalid = 0; inst_ready = 1;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093) begin errors++; $display("FAIL rf_inst got %0b/%h want 1/00500093", inst_valid, inst); end
    checks++; if (opcode !== 7'h13 || funct3 !== 3'd0) begin errors++; $display("FAIL rf_fields got %h/%0d want 13/0", opcode, funct3); end
    checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL rf_inst_pc got %h want 100", inst_pc); end
    step();
    inst_ready = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || inst_valid !== 1'b0) begin errors++; $display("FAIL rf_next got %0b/%h/%0b want 1/104/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_backpressure();
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00A0_0113; step();
    imem_rvalid = 0; inst_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00A0_0113 || inst_pc !== 32'h104 || imem_req !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%0b inst=%h pc=%h req=%0b want 1/00a00113/104/0", i, inst_valid, inst, inst_pc, imem_req);
      end
      step();
    end
    inst_ready = 1; step();
    inst_ready = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108 || inst_valid !== 1'b0) begin errors++; $display("FAIL bp_req got %0b/%h/%0b want 1/108/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1; step();
    imem_gnt = 0; redirect = 1; redirect_pc = 32'h200; step();
    redirect = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_flush%0d got req=%0b v=%0b want 0/0", i, imem_req, inst_valid); end
      step();
    end
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
    imem_rvalid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_restart got %0b/%h/%0b want 1/200/0", imem_req, imem_addr, inst_valid); end
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h4000_0033; step();
    imem_rvalid = 0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'h4000_0033) begin errors++; $display("FAIL rw_first got %0b/%h/%h want 1/200/40000033", inst_valid, inst_pc, inst); end
    checks++; if (opcode !== 7'h33 || funct7 !== 7'h20 || funct3 !== 3'd0) begin errors++; $display("FAIL rw_fields got %h/%h/%0d want 33/20/0", opcode, funct7, funct3); end
  endtask

  task automatic test_redirect_hold();
    redirect = 1; redirect_pc = 32'h303; inst_ready = 1; step();
    redirect = 0; inst_ready = 0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rh_target got %0b/%0b/%h want 0/1/300", inst_valid, imem_req, imem_addr); end
    imem_rvalid = 1; imem_rdata = 32'hBAD0_0000; step();
    imem_rvalid = 0;
    checks++; if (inst_valid !== 1'b0 || inst === 32'hBAD0_0000 || imem_addr !== 32'h300) begin errors++; $display("FAIL rh_stray got %0b/%h/%h want 0/not bad00000/300", inst_valid, inst, imem_addr); end
  endtask

  task automatic test_async_reset();
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678; step();
    imem_rvalid = 0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin errors++; $display("FAIL ar_hold got %0b/%h want 1/300", inst_valid, inst_pc); end
    #2 rst_n = 0;
    #1;
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h13 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL ar_now got v=%0b inst=%h req=%0b addr=%h want 0/00000013/0/100", inst_valid, inst, imem_req, imem_addr);
    end
    step();
    rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'hCAFE_0000; step();
    imem_rvalid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin errors++; $display("FAIL ar_restart got %0b/%h/%0b want 1/100/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_wrap();
    rst_n = 0; idle(); step();
    rst_n = 1; step();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first got %0b/%h want 1/fffffffc", w_req, w_addr); end
    imem_gnt = 1; step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013; step();
    imem_rvalid = 0; inst_ready = 1;
    checks++; if (w_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_inst_pc got %0b/%h want 1/fffffffc", w_valid, w_inst_pc); end
    step();
    inst_ready = 0;
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wr_second got %0b/%h want 1/00000000", w_req, w_addr); end
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
